// File: rtl/ex_div.sv
`default_nettype none
// ============================================================================
// Module   : ex_div
// Brief    : Iterative radix-2 restoring divider (DIV/DIVU) for the EX stage.
// Revision : 1.0 - initial release
// ============================================================================
module ex_div #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 annul,
    input  logic                 signed_div,
    input  logic [WIDTH-1:0]     opdata1,
    input  logic [WIDTH-1:0]     opdata2,
    output logic [2*WIDTH-1:0]   result,
    output logic                 ready,
    output logic                 busy
);

    localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_FREE     = 2'd0,
        S_DIV_ZERO = 2'd1,
        S_ON       = 2'd2,
        S_END      = 2'd3
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [WIDTH-1:0]     r_rem;
    logic [WIDTH-1:0]     r_dvd;
    logic [WIDTH-1:0]     r_dvs;
    logic                 r_s1;
    logic                 r_s2;
    logic                 r_sgn;
    logic [2*WIDTH-1:0]   r_result;
    logic                 r_ready;

    logic [WIDTH-1:0]     w_abs1;
    logic [WIDTH-1:0]     w_abs2;
    logic [WIDTH:0]       w_trial;
    logic [WIDTH:0]       w_diff;
    logic                 w_fits;
    logic [WIDTH-1:0]     w_rem_nx;
    logic [WIDTH-1:0]     w_quo_nx;
    logic [WIDTH-1:0]     w_rem_fix;
    logic [WIDTH-1:0]     w_quo_fix;
    logic                 w_neg_q;
    logic                 w_neg_r;

    // Magnitudes wrap mod 2^WIDTH, so the most negative value maps onto itself
    // and is still the correct unsigned magnitude.
    assign w_abs1 = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
    assign w_abs2 = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;

    // The partial remainder is always below the divisor, so the shifted trial
    // value needs one extra bit; a borrow out of that bit means "does not fit".
    assign w_trial  = {r_rem, r_dvd[WIDTH-1]};
    assign w_diff   = w_trial - {1'b0, r_dvs};
    assign w_fits   = ~w_diff[WIDTH];
    assign w_rem_nx = w_fits ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign w_quo_nx = {r_dvd[WIDTH-2:0], w_fits};

    assign w_neg_q   = r_sgn & (r_s1 ^ r_s2);
    assign w_neg_r   = r_sgn & r_s1;
    assign w_quo_fix = w_neg_q ? -w_quo_nx : w_quo_nx;
    assign w_rem_fix = w_neg_r ? -w_rem_nx : w_rem_nx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_FREE;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_sgn    <= 1'b0;
            r_result <= '0;
            r_ready  <= 1'b0;
        end else if (annul && (r_state != S_FREE)) begin
            r_state  <= S_FREE;
            r_cnt    <= '0;
            r_result <= '0;
            r_ready  <= 1'b0;
        end else begin
            case (r_state)
                S_FREE: begin
                    r_ready  <= 1'b0;
                    r_result <= '0;
                    if (start && !annul) begin
                        if (opdata2 == '0) begin
                            r_state <= S_DIV_ZERO;
                        end else begin
                            r_state <= S_ON;
                            r_cnt   <= '0;
                            r_rem   <= '0;
                            r_dvd   <= w_abs1;
                            r_dvs   <= w_abs2;
                            r_s1    <= opdata1[WIDTH-1];
                            r_s2    <= opdata2[WIDTH-1];
                            r_sgn   <= signed_div;
                        end
                    end
                end
                S_DIV_ZERO: begin
                    r_state  <= S_END;
                    r_result <= '0;
                    r_ready  <= 1'b0;
                end
                S_ON: begin
                    r_rem <= w_rem_nx;
                    r_dvd <= w_quo_nx;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_LAST) begin
                        r_result <= {w_rem_fix, w_quo_fix};
                        r_ready  <= 1'b1;
                        r_state  <= S_END;
                    end
                end
                S_END: begin
                    // Divide-by-zero arrives here with ready low; it rises one edge later.
                    if (start) begin
                        r_ready <= 1'b1;
                    end else begin
                        r_state  <= S_FREE;
                        r_ready  <= 1'b0;
                        r_result <= '0;
                    end
                end
                default: begin
                    r_state  <= S_FREE;
                    r_ready  <= 1'b0;
                    r_result <= '0;
                end
            endcase
        end
    end

    assign result = r_result;
    assign ready  = r_ready;
    assign busy   = (r_state != S_FREE);

endmodule
`default_nettype wire

// File: tb/tb_ex_div.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_div
// Brief    : Scoreboard-driven self-checking bench for ex_div.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_div;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           annul;
    logic           signed_div;
    logic [W-1:0]   opdata1;
    logic [W-1:0]   opdata2;
    logic [2*W-1:0] result;
    logic           ready;
    logic           busy;

    int             n_cmp = 0;
    int             n_bad = 0;
    logic [63:0]    sb_q[$];

    ex_div #(.WIDTH(W)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .annul      (annul),
        .signed_div (signed_div),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .result     (result),
        .ready      (ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        longint la, lb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            la = longint'($signed(a));
            lb = longint'($signed(b));
        end else begin
            la = longint'({32'd0, a});
            lb = longint'({32'd0, b});
        end
        q = la / lb;
        r = la % lb;
        return {r[31:0], q[31:0]};
    endfunction

    // Drives one request and collects what the DUT produces; no checking here.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          output logic [63:0] res, output int lat, output bit sig_ok, output bit got);
        int edges;
        @(negedge clk);
        opdata1 = a; opdata2 = b; signed_div = sgn; start = 1'b1;
        sb_q.push_back(model(a, b, sgn));
        edges = 0; got = 1'b0; sig_ok = 1'b1; res = '0;
        while (!got && edges < 100) begin
            @(posedge clk); #1;
            edges++;
            if (edges == 1) begin
                opdata1 = ~a; opdata2 = b + 32'd5; signed_div = ~sgn;
            end
            if (busy !== 1'b1) sig_ok = 1'b0;
            if (ready !== 1'b1 && result !== 64'd0) sig_ok = 1'b0;
            if (ready === 1'b1) begin
                got = 1'b1; res = result;
            end
        end
        lat = edges - 1;
    endtask

    task automatic drop_start(output logic rdy, output logic [63:0] res, output logic bsy);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        rdy = ready; res = result; bsy = busy;
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_cmp++;
        if (ready !== 1'b0 || busy !== 1'b0 || result !== 64'd0) begin
            n_bad++;
            $display("FAIL reset_state: ready=%b busy=%b result=%h, want 0/0/0", ready, busy, result);
        end
        rst = 1'b1;
    endtask

    task automatic test_divu;
        logic [63:0] res, exp; int lat; bit ok, got; logic rdy, bsy;
        run_op(32'd100, 32'd7, 1'b0, res, lat, ok, got);
        exp = sb_q.pop_front();
        n_cmp++;
        if (!got || res !== exp || res !== {32'd2, 32'd14}) begin
            n_bad++; $display("FAIL divu_100_7: got=%b result=%h want %h", got, res, exp);
        end
        n_cmp++;
        if (lat !== 32) begin n_bad++; $display("FAIL divu_latency: %0d edges, want 32", lat); end
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL divu_busy: busy dropped or result nonzero before ready"); end
        drop_start(rdy, res, bsy);
        n_cmp++;
        if (rdy !== 1'b0 || res !== 64'd0 || bsy !== 1'b0) begin
            n_bad++; $display("FAIL divu_release: ready=%b result=%h busy=%b, want 0/0/0", rdy, res, bsy);
        end
    endtask

    task automatic test_signed;
        logic [31:0] ta[3] = '{32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFF9};
        logic [31:0] tb[3] = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
        logic [63:0] tk[3] = '{{32'hFFFF_FFFF, 32'hFFFF_FFFD}, {32'd1, 32'hFFFF_FFFD}, {32'hFFFF_FFFF, 32'd3}};
        logic [63:0] res, exp; int lat; bit ok, got; logic rdy, bsy;
        for (int i = 0; i < 3; i++) begin
            run_op(ta[i], tb[i], 1'b1, res, lat, ok, got);
            exp = sb_q.pop_front();
            n_cmp++;
            if (!got || res !== exp || res !== tk[i]) begin
                n_bad++; $display("FAIL div_signed_%0d: got=%b result=%h want %h", i, got, res, tk[i]);
            end
            drop_start(rdy, res, bsy);
        end
    endtask

    task automatic test_overflow;
        logic [63:0] res, exp; int lat; bit ok, got; logic rdy, bsy;
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, res, lat, ok, got);
        exp = sb_q.pop_front();
        n_cmp++;
        if (!got || res !== exp || res !== {32'd0, 32'h8000_0000}) begin
            n_bad++; $display("FAIL div_min_by_m1: got=%b result=%h want %h", got, res, exp);
        end
        drop_start(rdy, res, bsy);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, res, lat, ok, got);
        exp = sb_q.pop_front();
        n_cmp++;
        if (!got || res !== exp || res !== {32'h8000_0000, 32'd0}) begin
            n_bad++; $display("FAIL divu_min_by_max: got=%b result=%h want %h", got, res, exp);
        end
        drop_start(rdy, res, bsy);
    endtask

    task automatic test_div_zero;
        logic [63:0] res, exp; int lat; bit ok, got; logic rdy, bsy;
        bit hold_ok;
        run_op(32'd1234, 32'd0, 1'b1, res, lat, ok, got);
        exp = sb_q.pop_front();
        n_cmp++;
        if (!got || res !== exp) begin n_bad++; $display("FAIL div_zero_result: got=%b result=%h want %h", got, res, exp); end
        n_cmp++;
        if (lat !== 2) begin n_bad++; $display("FAIL div_zero_latency: %0d edges, want 2", lat); end
        hold_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (ready !== 1'b1 || result !== 64'd0) hold_ok = 1'b0;
        end
        n_cmp++;
        if (!hold_ok) begin n_bad++; $display("FAIL div_zero_hold: ready=%b result=%h, want 1/0", ready, result); end
        drop_start(rdy, res, bsy);
        n_cmp++;
        if (rdy !== 1'b0 || bsy !== 1'b0) begin n_bad++; $display("FAIL div_zero_release: ready=%b busy=%b, want 0/0", rdy, bsy); end
    endtask

    task automatic test_annul;
        logic [63:0] res, exp; int lat; bit ok, got; logic rdy, bsy;
        bit early;
        @(negedge clk);
        opdata1 = 32'd5000; opdata2 = 32'd7; signed_div = 1'b0; start = 1'b1;
        early = 1'b0;
        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1;
            if (ready !== 1'b0) early = 1'b1;
        end
        @(negedge clk);
        annul = 1'b1;
        @(posedge clk); #1;
        annul = 1'b0;
        n_cmp++;
        if (early || ready !== 1'b0 || busy !== 1'b0 || result !== 64'd0) begin
            n_bad++; $display("FAIL annul: early=%b ready=%b busy=%b result=%h, want 0/0/0/0", early, ready, busy, result);
        end
        run_op(32'd5001, 32'd9, 1'b0, res, lat, ok, got);
        exp = sb_q.pop_front();
        n_cmp++;
        if (!got || res !== exp || lat !== 32) begin
            n_bad++; $display("FAIL annul_restart: got=%b result=%h lat=%0d want %h lat 32", got, res, lat, exp);
        end
        drop_start(rdy, res, bsy);
    endtask

    task automatic test_async_reset;
        logic [63:0] res, exp; int lat; bit ok, got; logic rdy, bsy;
        @(negedge clk);
        opdata1 = 32'd999; opdata2 = 32'd4; signed_div = 1'b0; start = 1'b1;
        for (int i = 0; i < 10; i++) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        n_cmp++;
        if (ready !== 1'b0 || busy !== 1'b0 || result !== 64'd0) begin
            n_bad++; $display("FAIL async_reset_on: ready=%b busy=%b result=%h, want 0/0/0", ready, busy, result);
        end
        @(negedge clk);
        start = 1'b0; rst = 1'b1;
        run_op(32'd77, 32'd5, 1'b0, res, lat, ok, got);
        exp = sb_q.pop_front();
        n_cmp++;
        if (!got || res !== exp) begin n_bad++; $display("FAIL post_reset_div: got=%b result=%h want %h", got, res, exp); end
        #3 rst = 1'b0;
        #1;
        n_cmp++;
        if (ready !== 1'b0 || busy !== 1'b0 || result !== 64'd0) begin
            n_bad++; $display("FAIL async_reset_end: ready=%b busy=%b result=%h, want 0/0/0", ready, busy, result);
        end
        @(negedge clk);
        start = 1'b0; rst = 1'b1;
    endtask

    task automatic test_back_to_back;
        logic [63:0] res, exp; int lat; bit ok, got; logic rdy, bsy;
        logic [31:0] a, b;
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
            if (b == 32'd0) b = 32'd1;
            run_op(a, b, i[0], res, lat, ok, got);
            exp = sb_q.pop_front();
            n_cmp++;
            if (!got || res !== exp || lat !== 32 || !ok) begin
                n_bad++;
                $display("FAIL b2b_%0d: a=%h b=%h s=%b got=%b result=%h lat=%0d ok=%b want %h", i, a, b, i[0], got, res, lat, ok, exp);
            end
            drop_start(rdy, res, bsy);
            n_cmp++;
            if (rdy !== 1'b0 || bsy !== 1'b0) begin
                n_bad++; $display("FAIL b2b_release_%0d: ready=%b busy=%b, want 0/0", i, rdy, bsy);
            end
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
        opdata1 = '0; opdata2 = '0;
        repeat (2) @(posedge clk);
        test_reset();
        test_divu();
        test_signed();
        test_overflow();
        test_div_zero();
        test_annul();
        test_async_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
